// File: rtl/tiny_fpga_pkg.sv
// Shared types and constants for the tiny FPGA configuration path.
package tiny_fpga_pkg;

  localparam int unsigned BITSTREAM_WORD_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CKSUM = 2'd2
  } bitstream_tx_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: load has priority over shift, MSB presented first.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift_en,
  output logic             msb
);

  logic [WIDTH-1:0] shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift_en) begin
      shreg <= {shreg[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = shreg[WIDTH-1];

endmodule

// File: rtl/bitstream_tx.sv
// Serializes configuration words MSB-first onto a 1-bit AXI-stream.
// Optional trailing XOR checksum word when BITSTREAM_TX_CHECKSUM_EN is defined.
module bitstream_tx
  import tiny_fpga_pkg::*;
#(
  parameter int unsigned WORD_WIDTH = BITSTREAM_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [WORD_WIDTH-1:0] in_tdata,
  input  logic                  in_tlast,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic                  out_tdata,
  output logic                  out_tlast,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(WORD_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_WIDTH - 1);

  bitstream_tx_state_e state, state_nxt;
  logic [CNT_W-1:0]    bit_cnt;
  logic                last_q;
  logic                accept;
  logic                out_hs;
  logic                last_bit;
  logic                piso_load;
  logic [WORD_WIDTH-1:0] piso_data;

  assign accept   = in_tvalid && in_tready;
  assign out_hs   = out_tvalid && out_tready;
  assign last_bit = (bit_cnt == LAST_CNT);

`ifdef BITSTREAM_TX_CHECKSUM_EN
  logic [WORD_WIDTH-1:0] checksum;
  logic                  cksum_start;
  logic                  cksum_done;

  assign cksum_start = (state == SHIFT) && out_hs && last_bit && last_q;
  assign cksum_done  = (state == CKSUM) && out_hs && last_bit;
  assign piso_load   = accept || cksum_start;
  assign piso_data   = accept ? in_tdata : checksum;

  // Running XOR of the frame; accept never coincides with cksum_done (in_tready is low in CKSUM)
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum ^ in_tdata;
    end else if (cksum_done) begin
      checksum <= '0;
    end
  end
`else
  assign piso_load = accept;
  assign piso_data = in_tdata;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (out_hs && last_bit && !accept) begin
`ifdef BITSTREAM_TX_CHECKSUM_EN
          state_nxt = last_q ? CKSUM : IDLE;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef BITSTREAM_TX_CHECKSUM_EN
      CKSUM: begin
        if (out_hs && last_bit) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // in_tready opens in SHIFT only on the final accepted bit of a non-last word for zero-bubble streaming
  always_comb begin
    in_tready  = 1'b0;
    out_tvalid = 1'b0;
    out_tlast  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_tready = 1'b1;
      end
      SHIFT: begin
        out_tvalid = 1'b1;
        busy       = 1'b1;
        in_tready  = last_bit && out_tready && !last_q;
`ifndef BITSTREAM_TX_CHECKSUM_EN
        out_tlast  = last_bit && last_q;
`endif
      end
`ifdef BITSTREAM_TX_CHECKSUM_EN
      CKSUM: begin
        out_tvalid = 1'b1;
        busy       = 1'b1;
        out_tlast  = last_bit;
      end
`endif
      default: begin
        in_tready = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      last_q  <= 1'b0;
    end else begin
      if (piso_load) begin
        bit_cnt <= '0;
      end else if (out_hs) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (accept) begin
        last_q <= in_tlast;
      end
    end
  end

  piso_shift_reg #(
    .WIDTH(WORD_WIDTH)
  ) u_piso (
    .clk      (clk),
    .rst      (rst),
    .load     (piso_load),
    .load_data(piso_data),
    .shift_en (out_hs),
    .msb      (out_tdata)
  );

endmodule

// File: tb/tb_bitstream_tx.sv
// Self-checking bench for bitstream_tx: directed per-cycle vector table plus randomized frames vs. a queue model.
// Honors BITSTREAM_TX_CHECKSUM_EN when the build defines it.
module tb_bitstream_tx;

  localparam int unsigned W = 8;
`ifdef BITSTREAM_TX_CHECKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_tvalid;
  logic         in_tready;
  logic [W-1:0] in_tdata;
  logic         in_tlast;
  logic         out_tvalid;
  logic         out_tready;
  logic         out_tdata;
  logic         out_tlast;
  logic         busy;

  int n_vec = 0;
  int n_err = 0;

  bitstream_tx #(.WORD_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_tvalid (in_tvalid),
    .in_tready (in_tready),
    .in_tdata  (in_tdata),
    .in_tlast  (in_tlast),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata (out_tdata),
    .out_tlast (out_tlast),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // exp = {out_tvalid, out_tdata, out_tlast, in_tready, busy}
  typedef struct packed {
    logic         rst;
    logic         iv;
    logic [W-1:0] id;
    logic         il;
    logic         otr;
    logic         chk;
    logic [4:0]   exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    bit           l;
  } word_t;

  typedef struct {
    bit d;
    bit l;
  } bit_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_vec(input bit r, input bit iv, input logic [W-1:0] id, input bit il,
                          input bit otr, input bit chk, input logic [4:0] exp);
    vec_t v;
    v.rst = r; v.iv = iv; v.id = id; v.il = il; v.otr = otr; v.chk = chk; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic add_idle(input bit iv, input logic [W-1:0] id, input bit il);
    push_vec(1'b0, iv, id, il, 1'b1, 1'b1, 5'b00010);
  endtask

  // All bits of one data word with out_tready held high; next word optionally presented throughout
  task automatic add_word(input logic [W-1:0] w, input bit frame_last,
                          input bit nv, input logic [W-1:0] nd, input bit nl);
    for (int i = 0; i < int'(W); i++) begin
      bit b;
      bit tl;
      bit itr;
      b   = w[W-1-i];
      tl  = frame_last && (i == int'(W) - 1) && !CK;
      itr = !frame_last && (i == int'(W) - 1);
      push_vec(1'b0, nv, nd, nl, 1'b1, 1'b1, {1'b1, b, tl, itr, 1'b1});
    end
  endtask

  task automatic add_cksum(input logic [W-1:0] c);
    for (int i = 0; i < int'(W); i++) begin
      bit b;
      b = c[W-1-i];
      push_vec(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, {1'b1, b, (i == int'(W) - 1), 1'b0, 1'b1});
    end
  endtask

  task automatic build_table();
    logic [W-1:0] w;
    bit           tr[10];
    int           bi[10];
    tr = '{1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    bi = '{0, 1, 1, 1, 2, 3, 4, 5, 6, 7};
    push_vec(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 5'b0);
    add_idle(1'b0, '0, 1'b0);
    // single word A5
    add_idle(1'b1, 8'hA5, 1'b1);
    add_word(8'hA5, 1'b1, 1'b0, '0, 1'b0);
    if (CK) add_cksum(8'hA5);
    add_idle(1'b0, '0, 1'b0);
    // back-to-back 0F, F0
    add_idle(1'b1, 8'h0F, 1'b0);
    add_word(8'h0F, 1'b0, 1'b1, 8'hF0, 1'b1);
    add_word(8'hF0, 1'b1, 1'b0, '0, 1'b0);
    if (CK) add_cksum(8'hFF);
    add_idle(1'b0, '0, 1'b0);
    // 81 with downstream stalls
    w = 8'h81;
    add_idle(1'b1, w, 1'b1);
    for (int k = 0; k < 10; k++) begin
      bit b;
      b = w[W-1-bi[k]];
      push_vec(1'b0, 1'b0, '0, 1'b0, tr[k], 1'b1, {1'b1, b, (bi[k] == 7) && !CK, 1'b0, 1'b1});
    end
    if (CK) add_cksum(8'h81);
    add_idle(1'b0, '0, 1'b0);
    // reset after 3rd bit of FF, then an all-zero frame
    add_idle(1'b1, 8'hFF, 1'b1);
    for (int k = 0; k < 3; k++) push_vec(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1, 5'b11001);
    push_vec(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 5'b11001);
    add_idle(1'b0, '0, 1'b0);
    add_idle(1'b1, 8'h00, 1'b1);
    add_word(8'h00, 1'b1, 1'b0, '0, 1'b0);
    if (CK) add_cksum(8'h00);
    add_idle(1'b0, '0, 1'b0);
    if (CK) begin
      add_idle(1'b1, 8'h12, 1'b0);
      add_word(8'h12, 1'b0, 1'b1, 8'h34, 1'b1);
      add_word(8'h34, 1'b1, 1'b0, '0, 1'b0);
      add_cksum(8'h26);
      add_idle(1'b0, '0, 1'b0);
    end
  endtask

  task automatic run_table();
    foreach (tbl[i]) begin
      @(posedge clk);
      #1;
      rst        = tbl[i].rst;
      in_tvalid  = tbl[i].iv;
      in_tdata   = tbl[i].id;
      in_tlast   = tbl[i].il;
      out_tready = tbl[i].otr;
      @(negedge clk);
      if (tbl[i].chk)
        check($sformatf("vec%0d {ov,od,ol,itr,busy}", i),
              32'({out_tvalid, out_tdata, out_tlast, in_tready, busy}), 32'(tbl[i].exp));
    end
  endtask

  task automatic run_random();
    word_t        words[$];
    bit_t         exp_q[$];
    logic [W-1:0] cks;
    int           wi;
    int           cyc;
    bit           presenting;
    bit           stall_prev;
    bit           prev_d;
    bit           prev_l;
    for (int f = 0; f < 30; f++) begin
      int n;
      n = int'($urandom_range(1, 4));
      for (int k = 0; k < n; k++) begin
        word_t wd;
        wd.d = W'($urandom);
        wd.l = (k == n - 1);
        words.push_back(wd);
      end
    end
    cks = '0; wi = 0; cyc = 0; presenting = 0; stall_prev = 0; prev_d = 0; prev_l = 0;
    while (wi < words.size() || exp_q.size() != 0) begin
      if (cyc >= 20000) begin
        check("random cycle budget", 32'(exp_q.size()), 32'd0);
        break;
      end
      cyc++;
      @(posedge clk);
      #1;
      rst        = 1'b0;
      out_tready = ($urandom_range(0, 3) != 0);
      if (!presenting && wi < words.size() && $urandom_range(0, 2) != 0) presenting = 1;
      in_tvalid = presenting;
      in_tdata  = presenting ? words[wi].d : W'($urandom);
      in_tlast  = presenting ? words[wi].l : 1'b0;
      @(negedge clk);
      if (stall_prev)
        check("stall hold {ov,od,ol}", 32'({out_tvalid, out_tdata, out_tlast}),
              32'({1'b1, prev_d, prev_l}));
      if (busy !== out_tvalid) check("busy vs out_tvalid", 32'(busy), 32'(out_tvalid));
      if (out_tvalid && out_tready) begin
        if (exp_q.size() == 0) begin
          check("unexpected output bit", 32'd1, 32'd0);
        end else begin
          bit_t e;
          e = exp_q.pop_front();
          check($sformatf("rand bit c%0d {od,ol}", cyc), 32'({out_tdata, out_tlast}), 32'({e.d, e.l}));
        end
      end
      stall_prev = out_tvalid && !out_tready;
      prev_d     = out_tdata;
      prev_l     = out_tlast;
      if (in_tvalid && in_tready) begin
        for (int i = 0; i < int'(W); i++) begin
          bit_t e;
          e.d = in_tdata[W-1-i];
          e.l = in_tlast && (i == int'(W) - 1) && !CK;
          exp_q.push_back(e);
        end
        cks = cks ^ in_tdata;
        if (in_tlast) begin
          if (CK) begin
            for (int i = 0; i < int'(W); i++) begin
              bit_t e;
              e.d = cks[W-1-i];
              e.l = (i == int'(W) - 1);
              exp_q.push_back(e);
            end
          end
          cks = '0;
        end
        presenting = 0;
        wi++;
      end
    end
    @(posedge clk);
    #1;
    in_tvalid = 1'b0;
    @(negedge clk);
    check("final idle {ov,itr,busy}", 32'({out_tvalid, in_tready, busy}), 32'b010);
  endtask

  initial begin
    rst        = 1'b1;
    in_tvalid  = 1'b0;
    in_tdata   = '0;
    in_tlast   = 1'b0;
    out_tready = 1'b0;
    build_table();
    run_table();
    run_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bitstream_tx.md
BITSTREAM_TX -- requirements
Module: bitstream_tx

Interface
REQ-001 SHALL have parameter WORD_WIDTH, default 8, meaning the width of each parallel configuration word (legal 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port in_tvalid  input  1  upstream word valid.
REQ-005 SHALL have port in_tready  output  1  word accepted when in_tvalid && in_tready at clk edge.
REQ-006 SHALL have port in_tdata  input  WORD_WIDTH  configuration word.
REQ-007 SHALL have port in_tlast  input  1  word is the final word of the bitstream frame.
REQ-008 SHALL have port out_tvalid  output  1  serial bit valid (AXI-stream master, DATA_WIDTH 1, drives the FPGA cfg_bitstream slave).
REQ-009 SHALL have port out_tready  input  1  downstream bit accept.
REQ-010 SHALL have port out_tdata  output  1  serial bit.
REQ-011 SHALL have port out_tlast  output  1  final bit of frame.
REQ-012 SHALL have port busy  output  1  high whenever state != IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and (only with the macro) CKSUM.
REQ-014 IDLE: in_tready=1, out_tvalid=0; on word accept, load the shift register with in_tdata, capture in_tlast and set bit_cnt=0; go to SHIFT.
REQ-015 SHIFT: out_tvalid=1; out_tdata = shreg MSB (MSB-first); on each out handshake, shift left by one and increment bit_cnt.
REQ-016 out_tdata and out_tlast SHALL hold stable while out_tvalid && !out_tready; out_tvalid SHALL NOT deassert before the handshake.
REQ-017 in_tready in SHIFT SHALL be 1 only in the cycle bit_cnt==WORD_WIDTH-1 && out_tready && captured last==0, so back-to-back words stream with zero bubble cycles.
REQ-018 At the last-bit handshake: a simultaneous new-word accept reloads the shift register (stays in SHIFT, bit_cnt=0); otherwise, for a non-last word go to IDLE, and for a last word go to IDLE (or CKSUM with the macro).
REQ-019 out_tlast SHALL be 1 only on the final bit of the frame (the last-word LSB without the macro; the checksum LSB with it).
REQ-020 Latency: the first bit SHALL be valid on out_tdata one cycle after the word handshake; frame throughput is 1 bit/cycle with out_tready held high.
REQ-021 A stalled out_tready SHALL stall the bit counter and backpressure in_tready without losing or duplicating bits.

Reset
REQ-022 rst SHALL force: state=IDLE, in_tready=1 on the next cycle, out_tvalid=0, out_tdata=0, out_tlast=0, busy=0, bit_cnt=0, shreg=0, checksum=0.
REQ-023 rst asserted mid-frame SHALL abandon the frame; no partial bits are emitted after reset deasserts.

Configuration
REQ-024 Macro BITSTREAM_TX_CHECKSUM_EN: when defined, SHALL XOR-accumulate every accepted word of the frame into a WORD_WIDTH checksum and serialize it MSB-first in CKSUM after the last word, with in_tready=0 during CKSUM; the checksum clears on frame end. When undefined, the CKSUM state and checksum register SHALL be absent and the frame ends on the last-word LSB.

Structure
REQ-025 The shared package tiny_fpga_pkg SHALL hold the bitstream_tx_state_e enum (IDLE/SHIFT/CKSUM) and the BITSTREAM_WORD_WIDTH default constant.
REQ-026 One sub-module, piso_shift_reg (parallel load, shift enable, MSB out), SHALL be instantiated once and reused for both data and checksum serialization.

Verification
REQ-027 WORD_WIDTH=8, single word 0xA5 with tlast, out_tready=1 -> bits 1,0,1,0,0,1,0,1 on 8 consecutive cycles; tlast on the 8th only (no macro).
REQ-028 Two words 0x0F, 0xF0 (last on the second), presented back-to-back -> 16 contiguous valid bits, in_tready pulses exactly once mid-frame, no bubble.
REQ-029 out_tready toggling 1,0,0,1 during word 0x81 -> out_tdata held through stalls; sequence 1,0,0,0,0,0,0,1 intact.
REQ-030 rst asserted after the 3rd bit of 0xFF -> next cycle out_tvalid=0, busy=0, in_tready=1; a subsequent 0x00 frame emits exactly 8 zeros.
REQ-031 With BITSTREAM_TX_CHECKSUM_EN, words 0x12, 0x34 (last) -> 24 bits, the last 8 = 0x26, tlast only on the 24th bit.
